// File: rtl/cam_fb_pkg.sv
// rtl/cam_fb_pkg.sv - shared state type, RGB565 field positions and clog2 helper
package cam_fb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FRAME   = 2'd2
  } cap_state_e;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - multi-flop synchroniser with level and rise/fall pulse outputs
module cam_sync_edge
  import cam_fb_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/cam_fb_writer.sv
// rtl/cam_fb_writer.sv - camera byte stream to decimated framebuffer writes
// Optional horizontal mirror input enabled by CAM_FB_MIRROR_EN.
module cam_fb_writer
  import cam_fb_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_LOG2  = 2,
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int ADDR_W      = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cam_pclk,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  input  logic [ADDR_W-1:0] y_offset,
`ifdef CAM_FB_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [15:0]       fb_wdata,
  output logic              frame_done,
  output logic              line_err
);

  localparam int CW = clog2(H_ACTIVE + 1);
  localparam int RW = clog2(V_ACTIVE + 1);
  localparam logic [CW-1:0] H_MAX  = CW'(H_ACTIVE);
  localparam logic [RW-1:0] V_MAX  = RW'(V_ACTIVE);
  localparam logic [CW-1:0] C_MASK = CW'((1 << SCALE_LOG2) - 1);
  localparam logic [RW-1:0] R_MASK = RW'((1 << SCALE_LOG2) - 1);

  if (SYNC_STAGES < 2 || SCALE_LOG2 < 0 || SCALE_LOG2 > 3 ||
      (FB_W * FB_H) > (1 << ADDR_W)) begin : g_param_check
    $error("cam_fb_writer: illegal parameter set");
  end

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;

  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_pclk (
    .clk(clk), .rst_n(rst_n), .d_i(cam_pclk),
    .level_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall)
  );
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_href (
    .clk(clk), .rst_n(rst_n), .d_i(cam_href),
    .level_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall)
  );
  cam_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_vsync (
    .clk(clk), .rst_n(rst_n), .d_i(cam_vsync),
    .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{pclk_lvl, pclk_fall, href_rise};

  // Data delayed by the same depth so it lines up with the synchronised pclk.
  logic [SYNC_STAGES-1:0][7:0] data_pipe_q;
  logic [7:0]                  data_s;
  assign data_s = data_pipe_q[SYNC_STAGES-1];

  cap_state_e state_q, state_d;

  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              err_q, err_d;
  logic              seen_q, seen_d;
  logic              run_q, run_d;
  logic              s1_vld_q, s1_vld_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  logic [15:0]       pix_q, pix_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
`ifdef CAM_FB_MIRROR_EN
  logic              mirror_q, mirror_d;
`endif

  logic in_frame, frame_start, sample, complete, keep;
  int   x_i, x_m, yr_i, ysum_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = FRAME;
      FRAME:   if (vs_rise) state_d = WAIT_VS;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_frame    = (state_q == FRAME);
    frame_start = (state_q == WAIT_VS) && vs_fall;
    // href_fall keeps a sample that races the end of line inside that line.
    sample      = in_frame && pclk_rise && (href_lvl || href_fall) && !vs_lvl;
    complete    = sample && phase_q;

    phase_d = phase_q;
    hi_d    = hi_q;
    col_d   = col_q;
    row_d   = row_q;
    err_d   = err_q;
    seen_d  = seen_q;
    run_d   = run_q;
`ifdef CAM_FB_MIRROR_EN
    mirror_d = mirror_q;
`endif

    if (!in_frame || vs_lvl)  phase_d = 1'b0;
    else if (sample)          phase_d = ~phase_q;
    else if (!href_lvl)       phase_d = 1'b0;

    if (sample && !phase_q) hi_d = data_s;

    if (frame_start) begin
      col_d  = '0;
      row_d  = '0;
      err_d  = 1'b0;
      seen_d = 1'b0;
      run_d  = enable;
`ifdef CAM_FB_MIRROR_EN
      mirror_d = mirror_x;
`endif
    end else if (in_frame) begin
      if (complete) begin
        if (col_q == H_MAX) err_d = 1'b1;
        else                col_d = col_q + 1'b1;
      end
      if (href_fall) begin
        col_d  = '0;
        seen_d = 1'b1;
        if (row_q == V_MAX) err_d = 1'b1;
        else                row_d = row_q + 1'b1;
      end
    end

    x_i  = int'(col_q >> SCALE_LOG2);
    yr_i = int'(row_q >> SCALE_LOG2);
`ifdef CAM_FB_MIRROR_EN
    x_m = mirror_q ? (FB_W - 1 - x_i) : x_i;
`else
    x_m = x_i;
`endif
    ysum_i = yr_i + int'($signed(y_offset));
    if (ysum_i < 0)          ysum_i = ysum_i + FB_H;
    else if (ysum_i >= FB_H) ysum_i = ysum_i - FB_H;

    keep = complete && run_q && (col_q != H_MAX) && (row_q != V_MAX) &&
           ((col_q & C_MASK) == '0) && ((row_q & R_MASK) == '0) &&
           (x_i < FB_W) && (yr_i < FB_H);

    s1_vld_d = keep;
    x_d      = x_q;
    y_d      = y_q;
    pix_d    = pix_q;
    if (keep) begin
      x_d   = ADDR_W'(x_m);
      y_d   = ADDR_W'(ysum_i);
      pix_d = {hi_q, data_s};
    end

    we_d    = s1_vld_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (s1_vld_q) begin
      waddr_d = ADDR_W'(int'(y_q) * FB_W + int'(x_q));
      wdata_d = pix_q;
    end

    done_d = in_frame && vs_rise && seen_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_pipe_q <= '0;
      state_q     <= IDLE;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      err_q       <= 1'b0;
      seen_q      <= 1'b0;
      run_q       <= 1'b0;
      s1_vld_q    <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      pix_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
`ifdef CAM_FB_MIRROR_EN
      mirror_q    <= 1'b0;
`endif
    end else begin
      data_pipe_q <= {data_pipe_q[SYNC_STAGES-2:0], cam_data};
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      col_q       <= col_d;
      row_q       <= row_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
      run_q       <= run_d;
      s1_vld_q    <= s1_vld_d;
      x_q         <= x_d;
      y_q         <= y_d;
      pix_q       <= pix_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
`ifdef CAM_FB_MIRROR_EN
      mirror_q    <= mirror_d;
`endif
    end
  end

  assign fb_we      = we_q;
  assign fb_waddr   = waddr_q;
  assign fb_wdata   = wdata_q;
  assign frame_done = done_q;
  assign line_err   = err_q;

endmodule

// File: doc/cam_fb_writer.md
Name: cam_fb_writer

Overview:
Parametrised successor to the fixed camera-capture path. Accepts the raw OV7670/OV7640 byte stream (PCLK/HREF/VSYNC/D[7:0]) and oversamples it in a single fast system clock. It assembles RGB565 pixels, decimates them by a power of two, optionally offsets and mirrors them, and emits framebuffer write strobes with linear addresses. It sits between the camera pins and the dual-port framebuffer (vgabuff) and replaces the external row/col arithmetic and the "fudge" offset logic.

Parameters:
- H_ACTIVE, 640: camera pixels per line before decimation.
- V_ACTIVE, 480: camera lines per frame before decimation.
- SCALE_LOG2, 2: decimation exponent; keep 1 of every 2^S pixels and 1 of every 2^S lines (range 0..3).
- FB_W, 160: framebuffer width in pixels.
- FB_H, 120: framebuffer height in pixels.
- ADDR_W, 15: framebuffer address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- SYNC_STAGES, 2: synchroniser depth for the camera inputs (minimum 2).

Ports:
- clk  in  1  system clock; at least 4x PCLK (100 MHz nominal).
- rst_n  in  1  asynchronous, active-low reset.
- cam_pclk  in  1  camera pixel clock, asynchronous.
- cam_vsync  in  1  camera VSYNC, active high.
- cam_href  in  1  camera HREF, active high.
- cam_data  in  8  camera data byte.
- enable  in  1  capture enable; sampled only at frame start.
- y_offset  in  ADDR_W  signed vertical offset in framebuffer lines, wrapped modulo FB_H.
- fb_we  out  1  one-cycle framebuffer write strobe.
- fb_waddr  out  ADDR_W  write address, y*FB_W + x.
- fb_wdata  out  16  RGB565 pixel (first camera byte in [15:8]).
- frame_done  out  1  one-cycle pulse at end of frame.
- line_err  out  1  sticky flag: a line exceeded H_ACTIVE or a frame exceeded V_ACTIVE; cleared at the next frame start.

Behaviour:
- Reset: all outputs 0; counters, byte phase, state and synchronisers cleared.
- Synchronisation: pclk, href, vsync and data each pass through SYNC_STAGES flops. The sample event is a rising edge of the synchronised pclk. Data is taken from the same stage as pclk.
- FSM states: IDLE, WAIT_VS, FRAME.
  - IDLE -> WAIT_VS after reset.
  - WAIT_VS -> FRAME on the synchronised vsync falling edge. At this transition: capture enable into run_q, clear row, col and line_err.
  - FRAME -> WAIT_VS on the vsync rising edge; pulse frame_done for one cycle, but only if at least one line was seen.
  - Reset mid-frame returns to IDLE, so the first partial frame is discarded.
- Byte phase: clears whenever href=0. Each sample event with href=1 toggles phase. Phase 0 latches the high byte; phase 1 completes the pixel.
- col: increments per completed pixel and clears on the href falling edge. row increments on the href falling edge.
- Saturation: col saturates at H_ACTIVE and row at V_ACTIVE. Any attempt to exceed either sets line_err; no writes occur while saturated.
- Decimation: keep a pixel when run_q=1, col[S-1:0]==0 and row[S-1:0]==0. Then x=col>>S and yr=row>>S.
- Bounds: drop the pixel if x>=FB_W or yr>=FB_H.
- Y wrap: y=(yr+y_offset) mod FB_H, computed with a single conditional add/subtract of FB_H, so |y_offset|<FB_H is required.
- Latency: the completing sample event occurs at cycle T. fb_we=1 during cycle T+2 only, with fb_waddr and fb_wdata valid in the same cycle. The pipeline is: register x/y at T+1, compute address at T+2.
- Throughput: at most one write per PCLK period; no backpressure. The framebuffer must accept every write.
- Simultaneous events: if an href falling edge and a completing sample land in the same cycle, the pixel uses the pre-increment row. A vsync rising edge aborts any half-assembled pixel.
- Address arithmetic: y*FB_W is a constant multiply with ADDR_W-bit result; no truncation is permitted, which the parameter check enforces.

Optional Feature:
- Macro: CAM_FB_MIRROR_EN.
- Defined: adds input port mirror_x (1 bit, sampled at frame start with enable). When set, x is replaced by FB_W-1-x before the address is computed; latency is unchanged.
- Undefined: the port is absent and x is used directly.

Decomposition:
- Package cam_fb_pkg holds:
  - FSM state enum (IDLE, WAIT_VS, FRAME);
  - function clog2;
  - RGB565 field constants (R 15:11, G 10:5, B 4:0).
- Sub-module cam_sync_edge: parametrised SYNC_STAGES synchroniser with rise/fall pulse outputs. Instantiated for pclk, href and vsync; data uses a plain delay chain of the same depth.

Test Plan:
- Default params, one 640x480 frame with PCLK = clk/4, bytes hi=8'hA5/lo=8'h5A, y_offset=0 -> exactly 19200 fb_we pulses, addresses 0..19199 in order, fb_wdata=16'hA55A, one frame_done pulse.
- Pixel (col 8, row 4), y_offset=-1 -> fb_waddr=0*160+2=2. Pixel (col 0, row 0), y_offset=-1 -> fb_waddr=119*160=19040.
- Line of 700 pixels -> no writes for cols >= 640, line_err=1; line_err clears after the next vsync falling edge.
- enable dropped mid-frame -> writes continue to frame end; the next frame produces 0 writes and frame_done still pulses.
- rst_n asserted mid-line -> fb_we=0 immediately; the current frame produces no writes; the next full frame produces 19200 writes.
- CAM_FB_MIRROR_EN defined with mirror_x=1: pixel (col 0, row 0) -> fb_waddr=159. SCALE_LOG2=1 with FB_W=320, FB_H=240: 76800 writes and fb_waddr max 76799 (ADDR_W=17).
